// File: rtl/i2c_controller_pkg.sv
// Shared types and constants for the single-byte I2C master write engine.
// Contents:
//   state_e    - controller FSM states
//   phase_e    - the four quarter phases of one bus slot
//   ADDR_BITS  - address byte width (7-bit address plus R/W)
//   DATA_BITS  - payload byte width
//   scl_high() - SCL level of a clocked slot for a given phase
package i2c_controller_pkg;

  localparam int unsigned ADDR_BITS = 8;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAddrAck,
    StData,
    StDataAck,
    StRstart,
    StStop
  } state_e;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_e;

  // Every slot except START holds SCL low for the first half and high for the second.
  function automatic logic scl_high(phase_e ph);
    return (ph == P2) || (ph == P3);
  endfunction

endpackage

// File: rtl/i2c_controller_if.sv
// Bundle of front-end and pad-side signals of i2c_controller.
// Signals:
//   enable, slave_address, data_in, repeated_start_cond - request side
//   sda_in                                               - sampled SDA line
//   sda_out, scl_out                                     - pad drives (1 = release)
//   busy, nack                                           - status
// Modports:
//   master - the controller itself
//   slave  - whatever drives the requests and observes the bus
interface i2c_controller_if;
  logic                                       enable;
  logic [i2c_controller_pkg::ADDR_BITS-1:0]   slave_address;
  logic [i2c_controller_pkg::DATA_BITS-1:0]   data_in;
  logic                                       repeated_start_cond;
  logic                                       sda_in;
  logic                                       sda_out;
  logic                                       scl_out;
  logic                                       busy;
  logic                                       nack;

  modport master (
    input  enable, slave_address, data_in, repeated_start_cond, sda_in,
    output sda_out, scl_out, busy, nack
  );

  modport slave (
    output enable, slave_address, data_in, repeated_start_cond, sda_in,
    input  sda_out, scl_out, busy, nack
  );
endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-period divider for the I2C controller.
// Ports:
//   core_clk - system clock
//   rst      - synchronous active-high reset
//   clear    - restart the slot at P0 with an empty quarter counter
//   tick     - high on the last core clock of each quarter
//   phase    - current quarter phase P0..P3 within the slot
module i2c_clk_gen
  import i2c_controller_pkg::*;
#(
  parameter int unsigned QTR = 1
) (
  input  logic   core_clk,
  input  logic   rst,
  input  logic   clear,
  output logic   tick,
  output phase_e phase
);

  localparam int unsigned QtrEff = (QTR < 1) ? 1 : QTR;
  localparam int unsigned CntW   = (QtrEff > 1) ? $clog2(QtrEff) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(QtrEff - 1);

  logic [CntW-1:0] qtr_q, qtr_d;
  logic [1:0]      ph_q, ph_d;

  always_comb begin
    tick  = (qtr_q == CntMax);
    qtr_d = tick ? '0 : qtr_q + 1'b1;
    ph_d  = tick ? ph_q + 2'd1 : ph_q;
    if (clear) begin
      qtr_d = '0;
      ph_d  = 2'd0;
    end
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      qtr_q <= '0;
      ph_q  <= 2'd0;
    end else begin
      qtr_q <= qtr_d;
      ph_q  <= ph_d;
    end
  end

  assign phase = phase_e'(ph_q);

endmodule

// File: rtl/i2c_controller.sv
// Single-byte I2C master write engine: START, address, ACK, data, ACK, then STOP
// or repeated START. Every bus slot is four phases of QTR core clocks each.
// Ports:
//   core_clk - system clock, all logic on its rising edge
//   rst      - synchronous active-high reset; aborts a transfer without a STOP
//   bus      - i2c_controller_if.master: requests, sda_in, sda_out/scl_out, busy, nack
module i2c_controller
  import i2c_controller_pkg::*;
#(
  parameter int unsigned QTR = 1
) (
  input logic             core_clk,
  input logic             rst,
  i2c_controller_if.master bus
);

  localparam logic [2:0] AddrMsb = 3'(ADDR_BITS - 1);
  localparam logic [2:0] DataMsb = 3'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_sr_q, addr_sr_d;
  logic [DATA_BITS-1:0] data_sr_q, data_sr_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic                 nack_q, nack_d;
  // Bus-free time satisfied; set after one full idle slot, or straight out of reset.
  logic                 free_q, free_d;

  logic   tick;
  phase_e phase;
  logic   clear;
  logic   slot_end;
  logic   sda, scl;

  i2c_clk_gen #(
    .QTR(QTR)
  ) u_clk_gen (
    .core_clk(core_clk),
    .rst     (rst),
    .clear   (clear),
    .tick    (tick),
    .phase   (phase)
  );

  assign slot_end = tick && (phase == P3);

  always_comb begin
    state_d   = state_q;
    addr_sr_d = addr_sr_q;
    data_sr_d = data_sr_q;
    bit_cnt_d = bit_cnt_q;
    nack_d    = nack_q;
    free_d    = free_q;
    clear     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (slot_end) begin
          free_d = 1'b1;
        end
        if (bus.enable && (free_q || slot_end)) begin
          state_d   = StStart;
          addr_sr_d = bus.slave_address;
          data_sr_d = bus.data_in;
          nack_d    = 1'b0;
          free_d    = 1'b0;
          clear     = 1'b1;
        end
      end
      StStart: begin
        if (slot_end) begin
          state_d   = StAddr;
          bit_cnt_d = AddrMsb;
        end
      end
      StAddr: begin
        if (slot_end) begin
          addr_sr_d = {addr_sr_q[ADDR_BITS-2:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            state_d = StAddrAck;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
      StAddrAck: begin
        if (slot_end) begin
          if (bus.sda_in) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            state_d   = StData;
            bit_cnt_d = DataMsb;
          end
        end
      end
      StData: begin
        if (slot_end) begin
          data_sr_d = {data_sr_q[DATA_BITS-2:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            state_d = StDataAck;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end
      StDataAck: begin
        if (slot_end) begin
          if (bus.sda_in) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (bus.repeated_start_cond) begin
            state_d = StRstart;
          end else begin
            state_d = StStop;
          end
        end
      end
      StRstart: begin
        if (slot_end) begin
          state_d   = StAddr;
          addr_sr_d = bus.slave_address;
          data_sr_d = bus.data_in;
          bit_cnt_d = AddrMsb;
        end
      end
      StStop: begin
        if (slot_end) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Line levels decoded from registered state and phase; SDA only moves with SCL high
  // inside START, RSTART and STOP.
  always_comb begin
    sda = 1'b1;
    scl = 1'b1;
    unique case (state_q)
      StIdle: begin
        sda = 1'b1;
        scl = 1'b1;
      end
      StStart: begin
        scl = 1'b1;
        sda = !scl_high(phase);
      end
      StAddr: begin
        scl = scl_high(phase);
        sda = addr_sr_q[ADDR_BITS-1];
      end
      StData: begin
        scl = scl_high(phase);
        sda = data_sr_q[DATA_BITS-1];
      end
      StAddrAck, StDataAck: begin
        scl = scl_high(phase);
        sda = 1'b1;
      end
      StRstart: begin
        scl = scl_high(phase);
        sda = (phase != P3);
      end
      StStop: begin
        scl = scl_high(phase);
        sda = (phase == P3);
      end
      default: begin
        sda = 1'b1;
        scl = 1'b1;
      end
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_sr_q <= '0;
      data_sr_q <= '0;
      bit_cnt_q <= 3'd0;
      nack_q    <= 1'b0;
      free_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      addr_sr_q <= addr_sr_d;
      data_sr_q <= data_sr_d;
      bit_cnt_q <= bit_cnt_d;
      nack_q    <= nack_d;
      free_q    <= free_d;
    end
  end

  assign bus.sda_out = sda;
  assign bus.scl_out = scl;
  assign bus.busy    = (state_q != StIdle);
  assign bus.nack    = nack_q;

endmodule

// File: tb/tb_i2c_controller.sv
module tb_i2c_controller;

  localparam int unsigned Q1 = 1;
  localparam int unsigned Q3 = 3;
  localparam int EvStart = 2;
  localparam int EvStop  = 3;

  logic core_clk = 1'b0;
  logic rst      = 1'b1;

  i2c_controller_if bus ();
  i2c_controller_if bus3 ();

  i2c_controller #(.QTR(Q1)) u_dut (
    .core_clk(core_clk),
    .rst     (rst),
    .bus     (bus)
  );

  i2c_controller #(.QTR(Q3)) u_dut3 (
    .core_clk(core_clk),
    .rst     (rst),
    .bus     (bus3)
  );

  always #5 core_clk = ~core_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus monitor and slave responder for the QTR=1 instance.
  int   got_ev[$];
  int   s_cnt      = 0;
  int   burst_base = 0;
  int   fall_cnt   = 0;
  int   busy_cnt   = 0;
  int   idle_cnt   = 0;
  bit   prev_scl   = 1'b1;
  bit   prev_sda   = 1'b1;
  bit   prev_busy  = 1'b0;
  bit   ack_addr[2];
  bit   ack_data[2];
  int   seg;

  always @(negedge core_clk) begin
    seg = ((s_cnt - burst_base) >= 2) ? 1 : 0;
    prev_scl  <= bus.scl_out;
    prev_sda  <= bus.sda_out;
    prev_busy <= bus.busy;
    if (prev_scl && bus.scl_out && prev_sda && !bus.sda_out) begin
      got_ev.push_back(EvStart);
      s_cnt    <= s_cnt + 1;
      fall_cnt <= 0;
    end else if (prev_scl && bus.scl_out && !prev_sda && bus.sda_out) begin
      got_ev.push_back(EvStop);
    end else if (!prev_scl && bus.scl_out) begin
      got_ev.push_back(int'(bus.sda_out));
    end
    // Slave drives ACK after the 8th and 17th bit, releasing one falling edge later.
    if (rst) begin
      bus.sda_in <= 1'b1;
    end else if (prev_scl && !bus.scl_out) begin
      fall_cnt <= fall_cnt + 1;
      case (fall_cnt + 1)
        9:       bus.sda_in <= !ack_addr[seg];
        18:      bus.sda_in <= !ack_data[seg];
        default: bus.sda_in <= 1'b1;
      endcase
    end
    if (bus.busy && !prev_busy) busy_cnt <= 1;
    else if (bus.busy) busy_cnt <= busy_cnt + 1;
    if (!bus.busy && prev_busy) idle_cnt <= 1;
    else if (!bus.busy) idle_cnt <= idle_cnt + 1;
  end

  task automatic run_burst(input int nseg, input bit chk_gap,
                           input logic [7:0] a0, input logic [7:0] d0, input bit aa0,
                           input bit da0, input logic [7:0] a1, input logic [7:0] d1,
                           input bit aa1, input bit da1);
    int exp_q[$];
    logic [7:0] a[2];
    logic [7:0] d[2];
    bit aa[2];
    bit da[2];
    int slots;
    bit exp_nack;
    int cyc;
    int gb;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
    aa[0] = aa0; aa[1] = aa1; da[0] = da0; da[1] = da1;
    slots    = 0;
    exp_nack = 1'b0;
    // Expected bus events: START/STOP conditions and the SDA level at each SCL rise.
    for (int s = 0; s < nseg; s++) begin
      exp_q.push_back(EvStart);
      slots++;
      for (int b = 7; b >= 0; b--) exp_q.push_back(int'(a[s][b]));
      exp_q.push_back(1);
      slots += 9;
      if (!aa[s]) begin
        exp_nack = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(EvStop);
        slots++;
        break;
      end
      for (int b = 7; b >= 0; b--) exp_q.push_back(int'(d[s][b]));
      exp_q.push_back(1);
      slots += 9;
      if (!da[s]) begin
        exp_nack = 1'b1;
        exp_q.push_back(0);
        exp_q.push_back(EvStop);
        slots++;
        break;
      end
      if (s == nseg - 1) begin
        exp_q.push_back(0);
        exp_q.push_back(EvStop);
        slots++;
      end else begin
        exp_q.push_back(1);
      end
    end

    ack_addr[0] = aa0; ack_addr[1] = aa1;
    ack_data[0] = da0; ack_data[1] = da1;
    burst_base  = s_cnt;
    gb          = got_ev.size();
    bus.slave_address       = a0;
    bus.data_in             = d0;
    bus.repeated_start_cond = (nseg > 1);
    bus.enable              = 1'b1;

    cyc = 0;
    do begin
      @(negedge core_clk);
      cyc++;
    end while (!bus.busy && cyc < 2000);
    if (!bus.busy) begin
      check_eq("busy_rise_timeout", 32'(bus.busy), 32'd1);
      bus.enable = 1'b0;
      return;
    end
    if (chk_gap) check_eq("idle_gap", idle_cnt, 4 * Q1);
    check_eq("nack_clr", 32'(bus.nack), 32'd0);
    bus.enable        = 1'b0;
    bus.slave_address = (nseg > 1) ? a1 : 8'($urandom);
    bus.data_in       = (nseg > 1) ? d1 : 8'($urandom);

    if (nseg > 1) begin
      cyc = 0;
      while (bus.busy && (s_cnt < burst_base + 2) && cyc < 4000) begin
        @(negedge core_clk);
        cyc++;
      end
      bus.repeated_start_cond = 1'b0;
    end

    cyc = 0;
    while (bus.busy && cyc < 4000) begin
      @(negedge core_clk);
      cyc++;
    end
    if (bus.busy) begin
      check_eq("busy_fall_timeout", 32'(bus.busy), 32'd0);
      return;
    end
    @(negedge core_clk);
    check_eq("busy_len", busy_cnt, slots * 4 * Q1);
    check_eq("nack", 32'(bus.nack), 32'(exp_nack));
    check_eq("ev_count", got_ev.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("ev%0d", i), (gb + i < got_ev.size()) ? got_ev[gb + i] : -1, exp_q[i]);
    end
  endtask

  // QTR=3 instance: one ACKed write, checking SCL run lengths and conditions.
  task automatic run_qtr3();
    bit ps, pd, seen_busy, have_rise;
    int low_len, high_len, n_s, n_p, b_len, cyc;
    bus3.slave_address       = 8'h5A;
    bus3.data_in             = 8'hC3;
    bus3.repeated_start_cond = 1'b0;
    bus3.sda_in              = 1'b0;
    bus3.enable              = 1'b1;
    ps = 1'b1; pd = 1'b1; seen_busy = 1'b0; have_rise = 1'b0;
    low_len = 0; high_len = 0; n_s = 0; n_p = 0; b_len = 0; cyc = 0;
    while (cyc < 1000 && !(seen_busy && !bus3.busy)) begin
      @(negedge core_clk);
      cyc++;
      if (bus3.busy) begin
        seen_busy   = 1'b1;
        bus3.enable = 1'b0;
        b_len++;
      end
      if (ps && bus3.scl_out && pd && !bus3.sda_out) n_s++;
      if (ps && bus3.scl_out && !pd && bus3.sda_out) n_p++;
      if (ps && !bus3.scl_out) begin
        if (have_rise) check_eq("q3_scl_high", high_len, 2 * Q3);
        low_len = 1;
      end else if (!ps && bus3.scl_out) begin
        check_eq("q3_scl_low", low_len, 2 * Q3);
        have_rise = 1'b1;
        high_len  = 1;
      end else if (bus3.scl_out) begin
        high_len++;
      end else begin
        low_len++;
      end
      ps = bus3.scl_out;
      pd = bus3.sda_out;
    end
    check_eq("q3_done", 32'(seen_busy && !bus3.busy), 32'd1);
    check_eq("q3_busy_len", b_len, 80 * Q3);
    check_eq("q3_starts", n_s, 1);
    check_eq("q3_stops", n_p, 1);
    check_eq("q3_nack", 32'(bus3.nack), 32'd0);
  endtask

  initial begin
    int cyc;
    int gb;
    bus.enable = 1'b0;
    bus.slave_address = 8'h00;
    bus.data_in = 8'h00;
    bus.repeated_start_cond = 1'b0;
    bus3.enable = 1'b0;
    bus3.slave_address = 8'h00;
    bus3.data_in = 8'h00;
    bus3.repeated_start_cond = 1'b0;
    bus3.sda_in = 1'b1;
    ack_addr[0] = 1'b0; ack_addr[1] = 1'b0;
    ack_data[0] = 1'b0; ack_data[1] = 1'b0;

    rst = 1'b1;
    repeat (8) @(negedge core_clk);
    check_eq("rst_sda", 32'(bus.sda_out), 32'd1);
    check_eq("rst_scl", 32'(bus.scl_out), 32'd1);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_nack", 32'(bus.nack), 32'd0);
    rst = 1'b0;
    gb = got_ev.size();
    repeat (12) @(negedge core_clk);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
    check_eq("idle_events", got_ev.size() - gb, 0);

    run_qtr3();

    // Address NACK, then two ACKed writes (STOP and repeated START).
    run_burst(1, 1'b0, 8'hF0, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_burst(1, 1'b1, 8'hF0, 8'hA5, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    run_burst(2, 1'b1, 8'hF0, 8'hA5, 1'b1, 1'b1, 8'h3C, 8'h96, 1'b1, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run_burst(int'($urandom_range(1, 2)), 1'b1,
                8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end

    // Reset during data bit 3 of an ACKed write.
    ack_addr[0] = 1'b1; ack_data[0] = 1'b1;
    burst_base = s_cnt;
    gb = got_ev.size();
    bus.slave_address = 8'h42;
    bus.data_in = 8'hFF;
    bus.repeated_start_cond = 1'b0;
    bus.enable = 1'b1;
    cyc = 0;
    while ((got_ev.size() - gb) < 15 && cyc < 2000) begin
      @(negedge core_clk);
      cyc++;
      if (bus.busy) bus.enable = 1'b0;
    end
    check_eq("mid_reached", 32'((got_ev.size() - gb) >= 15), 32'd1);
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge core_clk);
    #1;
    check_eq("mid_rst_sda", 32'(bus.sda_out), 32'd1);
    check_eq("mid_rst_scl", 32'(bus.scl_out), 32'd1);
    check_eq("mid_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_rst_nack", 32'(bus.nack), 32'd0);
    @(negedge core_clk);
    rst = 1'b0;
    repeat (3) @(negedge core_clk);

    run_burst(1, 1'b0, 8'hA4, 8'h5B, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    run_burst(1, 1'b1, 8'h7E, 8'h81, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
